// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(31,k) Chien search block.
// GF(2^5) field parameters, FSM state type and alpha power constants.
package bch_pkg;

  localparam int BCH_N = 31;
  localparam int BCH_M = 5;
  localparam int BCH_T = 3;

  // x^5 + x^2 + 1
  localparam logic [5:0] PRIM_POLY = 6'b100101;

  localparam logic [4:0] ALPHA1 = 5'b00010;
  localparam logic [4:0] ALPHA2 = 5'b00100;
  localparam logic [4:0] ALPHA3 = 5'b01000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/bch_chien_search_gf32_mul.sv
// GF(2^5) combinational multiplier, reduced by bch_pkg::PRIM_POLY.
// Ports: a_i, b_i operands; p_o product.
module gf32_mul
  import bch_pkg::*;
#(
  parameter int M = BCH_M
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] p_o
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  // Shift-and-add; sh walks a_i * x^i mod poly.
  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int i = 0; i < M; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0}
         ^ (sh[M-1] ? PRIM_POLY[M-1:0] : '0);
    end
  end

  assign p_o = acc;

endmodule

// File: rtl/bch_chien_search.sv
// Chien search for BCH(31,k), t=3: evaluates the error locator at
// alpha^0..alpha^30, one point per cycle, and reports error positions.
// Ports: clk, reset (async, active-high), start, sigma0..3, L,
//   codeword_in -> busy, done, err_vec, corrected, root_count, fail.
// Macro BCH_CHIEN_CORRECT_EN enables the codeword latch and the
//   corrected output; without it corrected is held at 0.
module bch_chien_search
  import bch_pkg::*;
#(
  parameter int N = BCH_N,
  parameter int M = BCH_M,
  parameter int T = BCH_T
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] sigma0,
  input  logic [M-1:0] sigma1,
  input  logic [M-1:0] sigma2,
  input  logic [M-1:0] sigma3,
  input  logic [3:0]   L,
  input  logic [N-1:0] codeword_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] err_vec,
  output logic [N-1:0] corrected,
  output logic [4:0]   root_count,
  output logic         fail
);

  state_e state_q, state_d;

  logic [M-1:0] sig0_q;
  logic [M-1:0] r1_q, r2_q, r3_q;
  logic [M-1:0] r1_d, r2_d, r3_d;
  logic         sigz_q;
  logic [3:0]   l_q;
  logic [4:0]   idx_q;
  logic [4:0]   cnt_q;
  logic [N-1:0] acc_q;
  logic [N-1:0] err_q;
  logic         fail_q;

  logic [M-1:0] sum;
  logic         hit;
  logic         last;
  logic [4:0]   pos;
  logic         fail_d;
  logic         load;

  gf32_mul #(.M(M)) u_mul1 (
    .a_i (r1_q),
    .b_i (ALPHA1),
    .p_o (r1_d)
  );

  gf32_mul #(.M(M)) u_mul2 (
    .a_i (r2_q),
    .b_i (ALPHA2),
    .p_o (r2_d)
  );

  gf32_mul #(.M(M)) u_mul3 (
    .a_i (r3_q),
    .b_i (ALPHA3),
    .p_o (r3_d)
  );

  // sigma(alpha^idx); a root at alpha^idx marks position -idx mod 31.
  assign sum  = sig0_q ^ r1_q ^ r2_q ^ r3_q;
  assign hit  = (sum == '0);
  assign last = (idx_q == 5'(N - 1));
  assign pos  = (idx_q == '0) ? '0 : 5'(N) - idx_q;
  assign load = (state_q == IDLE) && start;

  assign fail_d = (l_q > 4'(T))
               || ({1'b0, l_q} != cnt_q)
               || sigz_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SEARCH;
      end
      SEARCH: begin
        if (last) state_d = CHECK;
      end
      CHECK: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig0_q <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      sigz_q <= 1'b0;
      l_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      err_q  <= '0;
      fail_q <= 1'b0;
    end else if (load) begin
      sig0_q <= sigma0;
      r1_q   <= sigma1;
      r2_q   <= sigma2;
      r3_q   <= sigma3;
      sigz_q <= ~|{sigma0, sigma1, sigma2, sigma3};
      l_q    <= L;
      idx_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == SEARCH) begin
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      idx_q <= idx_q + 5'd1;
      if (hit) begin
        acc_q[pos] <= 1'b1;
        if (cnt_q != 5'h1f) cnt_q <= cnt_q + 5'd1;
      end
    end else if (state_q == CHECK) begin
      fail_q <= fail_d;
      err_q  <= fail_d ? '0 : acc_q;
    end
  end

`ifdef BCH_CHIEN_CORRECT_EN
  logic [N-1:0] cw_q;
  logic [N-1:0] corr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw_q   <= '0;
      corr_q <= '0;
    end else if (load) begin
      cw_q <= codeword_in;
    end else if (state_q == CHECK) begin
      corr_q <= cw_q ^ (fail_d ? '0 : acc_q);
    end
  end

  assign corrected = corr_q;
`else
  logic unused_cw;
  assign unused_cw = ^codeword_in;
  assign corrected = '0;
`endif

  assign err_vec    = err_q;
  assign root_count = cnt_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_bch_chien_search.sv
// Randomized self-checking bench for bch_chien_search.
// Reference: log/antilog GF(32) tables and direct polynomial evaluation.
module tb_bch_chien_search;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  sigma0, sigma1, sigma2, sigma3;
  logic [3:0]  L;
  logic [30:0] codeword_in;
  logic        busy, done, fail;
  logic [30:0] err_vec, corrected;
  logic [4:0]  root_count;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] expt [0:30];
  int         logt [0:31];

  bch_chien_search dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sigma0      (sigma0),
    .sigma1      (sigma1),
    .sigma2      (sigma2),
    .sigma3      (sigma3),
    .L           (L),
    .codeword_in (codeword_in),
    .busy        (busy),
    .done        (done),
    .err_vec     (err_vec),
    .corrected   (corrected),
    .root_count  (root_count),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gmul(input logic [4:0] a,
                                      input logic [4:0] b);
    if (a == 5'd0 || b == 5'd0) return 5'd0;
    return expt[(logt[a] + logt[b]) % 31];
  endfunction

  // Evaluate sigma at every nonzero field element alpha^i directly.
  task automatic model(input logic [4:0] s0, s1, s2, s3,
                       input logic [3:0] l,
                       output logic [30:0] ev, output int rc,
                       output logic fl);
    logic [30:0] acc;
    logic [4:0]  v;
    acc = '0;
    rc  = 0;
    for (int i = 0; i < 31; i++) begin
      v = s0 ^ gmul(s1, expt[i])
             ^ gmul(s2, expt[(2 * i) % 31])
             ^ gmul(s3, expt[(3 * i) % 31]);
      if (v == 5'd0) begin
        rc++;
        acc[(31 - i) % 31] = 1'b1;
      end
    end
    fl = (l > 4'd3) || (rc != int'(l))
      || ({s0, s1, s2, s3} == 20'd0);
    ev = fl ? 31'd0 : acc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err_vec), 32'd0);
    chk({tag, ".corr"}, 32'(corrected), 32'd0);
    chk({tag, ".rc"}, 32'(root_count), 32'd0);
    chk({tag, ".fail"}, 32'(fail), 32'd0);
  endtask

  // Cycle c runs from posedge c-1 to posedge c (posedge 0 samples
  // start); outputs are sampled at the negedge inside cycle c.
  task automatic run(input string tag,
                     input logic [4:0] s0, s1, s2, s3,
                     input logic [3:0] l, input logic [30:0] cw,
                     input int poke, input int rst_at);
    logic [30:0] ev, ecorr;
    int          rc;
    logic        fl;
    model(s0, s1, s2, s3, l, ev, rc, fl);
`ifdef BCH_CHIEN_CORRECT_EN
    ecorr = cw ^ ev;
`else
    ecorr = '0;
`endif
    @(negedge clk);
    sigma0 = s0; sigma1 = s1; sigma2 = s2; sigma3 = s3;
    L = l; codeword_in = cw; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    sigma0 = 5'($urandom); sigma1 = 5'($urandom);
    sigma2 = 5'($urandom); sigma3 = 5'($urandom);
    L = 4'($urandom); codeword_in = 31'($urandom);
    for (int c = 1; c <= 34; c++) begin
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        chk_zero({tag, ".rst"});
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      start = (c == poke);
      chk({tag, ".busy"}, 32'(busy), 32'(c <= 33));
      chk({tag, ".done"}, 32'(done), 32'(c == 33));
      if (c >= 33) begin
        chk({tag, ".err"}, 32'(err_vec), 32'(ev));
        chk({tag, ".rc"}, 32'(root_count), 32'(rc));
        chk({tag, ".fail"}, 32'(fail), 32'(fl));
        chk({tag, ".corr"}, 32'(corrected), 32'(ecorr));
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic rand_case(input int k);
    logic [4:0]  p [0:3];
    logic [30:0] used;
    logic [4:0]  a;
    int          ne, q;
    string       tag;
    tag = $sformatf("rnd%0d", k);
    if ($urandom_range(0, 3) == 3) begin
      run(tag, 5'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 4'($urandom_range(0, 15)),
          31'($urandom), 0, 0);
    end else begin
      p[0] = 5'd1; p[1] = '0; p[2] = '0; p[3] = '0;
      used = '0;
      ne   = $urandom_range(0, 3);
      for (int e = 0; e < ne; e++) begin
        do q = $urandom_range(0, 30); while (used[q]);
        used[q] = 1'b1;
        a = expt[q];
        for (int j = 3; j >= 1; j--) p[j] = p[j] ^ gmul(a, p[j-1]);
      end
      run(tag, p[0], p[1], p[2], p[3], 4'(ne),
          31'($urandom), 0, 0);
    end
  endtask

  initial begin
    expt[0] = 5'd1;
    for (int i = 1; i < 31; i++)
      expt[i] = {expt[i-1][3:0], 1'b0}
              ^ (expt[i-1][4] ? 5'b00101 : 5'b00000);
    for (int i = 0; i < 32; i++) logt[i] = 0;
    for (int i = 0; i < 31; i++) logt[expt[i]] = i;

    reset = 1'b1; start = 1'b0;
    sigma0 = '0; sigma1 = '0; sigma2 = '0; sigma3 = '0;
    L = '0; codeword_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("por");

    run("noerr", 5'd1, 5'd0, 5'd0, 5'd0, 4'd0,
        31'h2AB3_C4D5, 0, 0);
    run("pos5", 5'b00001, 5'b00101, 5'd0, 5'd0, 4'd1,
        31'h1234_5678, 0, 0);
    run("pos01", 5'b00001, 5'b00011, 5'b00010, 5'd0, 4'd2,
        31'h7FFF_0000, 0, 0);
    run("fail", 5'b00001, 5'd0, 5'd0, 5'd0, 4'd1,
        31'h0F0F_0F0F, 0, 0);
    run("rstmid", 5'b00001, 5'b00101, 5'd0, 5'd0, 4'd1,
        31'h5555_5555, 0, 10);
    run("after", 5'b00001, 5'b00011, 5'b00010, 5'd0, 4'd2,
        31'h3333_3333, 0, 0);
    run("poke", 5'b00001, 5'b00101, 5'd0, 5'd0, 4'd1,
        31'h0000_FFFF, 5, 0);
    run("zero", 5'd0, 5'd0, 5'd0, 5'd0, 4'd0,
        31'h1111_1111, 0, 0);
    for (int k = 0; k < 14; k++) rand_case(k);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
